// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory with a byte/half/word load-store
// unit in front of it. Requests are accepted through a valid/ready handshake;
// the response appears READ_LAT clock edges after acceptance as a one-cycle
// resp_valid pulse. Stores commit at the acceptance edge. A combinational
// debug port reads any word for the board-level memory viewer.
module data_mem_lsu #(
    parameter int    DEPTH     = 4096,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Storage array; the debug port and the load path both read it directly.
    logic [31:0] mem [DEPTH];

    // Registered control/response state.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Request snapshot taken at acceptance, consumed when RESP is entered.
    logic [31:0] hold_word_q, hold_word_d;
    logic [1:0]  hold_off_q, hold_off_d;
    logic [1:0]  hold_size_q, hold_size_d;
    logic        hold_uns_q, hold_uns_d;
    logic        hold_we_q, hold_we_d;
    logic        hold_err_q, hold_err_d;

    // Request decode.
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          req_err;
    logic          accept;
    logic          mem_we;
    logic [3:0]    be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;

    assign word_idx     = req_addr[AW+1:2];
    assign out_of_range = |req_addr[31:AW+2];
    assign req_ready    = req_ready_q && !rst;
    assign accept       = req_valid && req_ready;
    assign mem_we       = accept && req_we && !req_err;
    assign rd_word      = mem[word_idx];
    assign dbg_data     = mem[dbg_addr];

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;

    // Picks the byte or half selected by the low address bits and extends it.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: extend_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: extend_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            SZ_WORD: extend_load = word;
            default: extend_load = 32'b0;
        endcase
    endfunction

    // Error classification and store lane steering (data replicated per lane).
    always_comb begin
        req_err = out_of_range;
        be      = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                be      = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                if (req_addr[0]) begin
                    req_err = 1'b1;
                end
                be      = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                if (req_addr[1:0] != 2'b00) begin
                    req_err = 1'b1;
                end
                be = 4'b1111;
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
    end

    // Source of the response: the live request when RESP is entered straight
    // from IDLE (READ_LAT=1), otherwise the snapshot held since acceptance.
    logic [31:0] src_word;
    logic [1:0]  src_off;
    logic [1:0]  src_size;
    logic        src_uns;
    logic        src_we;
    logic        src_err;

    assign src_word = (state_q == IDLE) ? rd_word      : hold_word_q;
    assign src_off  = (state_q == IDLE) ? req_addr[1:0] : hold_off_q;
    assign src_size = (state_q == IDLE) ? req_size     : hold_size_q;
    assign src_uns  = (state_q == IDLE) ? req_unsigned : hold_uns_q;
    assign src_we   = (state_q == IDLE) ? req_we       : hold_we_q;
    assign src_err  = (state_q == IDLE) ? req_err      : hold_err_q;

    // Next-state, latency counter and registered output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        hold_word_d  = hold_word_q;
        hold_off_d   = hold_off_q;
        hold_size_d  = hold_size_q;
        hold_uns_d   = hold_uns_q;
        hold_we_d    = hold_we_q;
        hold_err_d   = hold_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_word_d = rd_word;
                    hold_off_d  = req_addr[1:0];
                    hold_size_d = req_size;
                    hold_uns_d  = req_unsigned;
                    hold_we_d   = req_we;
                    hold_err_d  = req_err;
                    if (READ_LAT == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                // The edge that brings cnt to zero is the one entering RESP.
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Response data/err only move on entry to RESP.
        if (state_d == RESP && state_q != RESP) begin
            resp_err_d   = src_err;
            resp_rdata_d = (src_we || src_err) ? 32'b0
                         : extend_load(src_word, src_off, src_size, src_uns);
        end

        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    // Control state and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            hold_word_q  <= 32'b0;
            hold_off_q   <= 2'b00;
            hold_size_q  <= 2'b00;
            hold_uns_q   <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            hold_word_q  <= hold_word_d;
            hold_off_q   <= hold_off_d;
            hold_size_q  <= hold_size_d;
            hold_uns_q   <= hold_uns_d;
            hold_we_q    <= hold_we_d;
            hold_err_q   <= hold_err_d;
        end
    end

    // Byte-enabled array write at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance with READ_LAT=1 runs a table
// of load/store vectors, a second with READ_LAT=4 covers back-to-back timing
// and reset during WAIT. Both use DEPTH=16 so out-of-range is easy to reach.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;

    logic        v1 = 1'b0, v4 = 1'b0;
    logic        ready1, ready4, rv1, rv4, er1, er4;
    logic [31:0] rd1, rd4, dbg_d1, dbg_d4;
    logic [3:0]  dbg_a1 = 4'd0, dbg_a4 = 4'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH(16), .READ_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(er1), .dbg_addr(dbg_a1), .dbg_data(dbg_d1)
    );

    data_mem_lsu #(.DEPTH(16), .READ_LAT(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(ready4),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv4),
        .resp_rdata(rd4), .resp_err(er4), .dbg_addr(dbg_a4), .dbg_data(dbg_d4)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One request on the chosen instance; returns response and its latency.
    task automatic xact(input int inst, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic pulse_ok);
        int w;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        if (inst == 1) v1 = 1'b1; else v4 = 1'b1;
        w = 0;
        while (!((inst == 1) ? ready1 : ready4) && w < 30) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        lat = 1;
        while (!((inst == 1) ? rv1 : rv4) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (w >= 30) lat = -1;
        rd = (inst == 1) ? rd1 : rd4;
        er = (inst == 1) ? er1 : er4;
        @(negedge clk);
        pulse_ok = !((inst == 1) ? rv1 : rv4);
    endtask

    task automatic run_vec(input int i);
        logic [31:0] rd;
        logic er, pulse_ok;
        int lat;
        xact(1, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat, pulse_ok);
        chk($sformatf("vec%0d_lat", i), lat, 1);
        chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
        chk($sformatf("vec%0d_pulse", i), {31'b0, pulse_ok}, 32'd1);
        $display("vec%0d we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 i, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic er, pulse_ok;
        int lat;
        logic [14:0] rdy_seen, rv_seen;
        logic any_rv;

        //         we  size  uns addr          wdata          exp_rd         err
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321, 32'h0,          1'b0}); // 0
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h8765_4321,  1'b0}); // 1
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h00, 32'h0BAD_F00D, 32'h0,          1'b0}); // 2
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h04, 32'h0000_0000, 32'h0,          1'b0}); // 3
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h08, 32'h1122_3344, 32'h0,          1'b0}); // 4
        vt.push_back('{1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB, 32'h0,          1'b0}); // 5
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hAB65_4321,  1'b0}); // 6
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'hFFFF_FFAB,  1'b0}); // 7
        vt.push_back('{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h0000_00AB,  1'b0}); // 8
        vt.push_back('{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF_AB65,  1'b0}); // 9
        vt.push_back('{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'h0000_AB65,  1'b0}); // 10
        vt.push_back('{1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FF55, 32'h0,          1'b0}); // 11
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         32'h1122_5544,  1'b0}); // 12
        vt.push_back('{1'b0, 2'b01, 1'b1, 32'h08, 32'h0,         32'h0000_5544,  1'b0}); // 13
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h0A, 32'h0,         32'h0000_0022,  1'b0}); // 14
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h11, 32'h0,         32'h0,          1'b1}); // 15
        vt.push_back('{1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_FFFF, 32'h0,          1'b1}); // 16
        vt.push_back('{1'b1, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,          1'b1}); // 17
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         32'h0,          1'b1}); // 18
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h44, 32'h0000_DEAD, 32'h0,          1'b1}); // 19
        vt.push_back('{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,          1'b1}); // 20
        vt.push_back('{1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_BEEF, 32'h0,          1'b0}); // 21
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h04, 32'h0,         32'hBEEF_0000,  1'b0}); // 22
        vt.push_back('{1'b0, 2'b00, 1'b1, 32'h04, 32'h0,         32'h0,          1'b0}); // 23
        vt.push_back('{1'b0, 2'b01, 1'b1, 32'h04, 32'h0,         32'h0,          1'b0}); // 24
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h07, 32'h0,         32'hFFFF_FFBE,  1'b0}); // 25
        vt.push_back('{1'b0, 2'b01, 1'b1, 32'h06, 32'h0,         32'h0000_BEEF,  1'b0}); // 26

        // Reset behaviour: ready held low during reset, idle outputs after.
        repeat (3) @(negedge clk);
        chk("rst_ready1_low", {31'b0, ready1}, 32'd0);
        chk("rst_ready4_low", {31'b0, ready4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready1", {31'b0, ready1}, 32'd1);
        chk("rst_rv1", {31'b0, rv1}, 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_err1", {31'b0, er1}, 32'd0);
        chk("rst_ready4", {31'b0, ready4}, 32'd1);

        // READ_LAT=1 vector table.
        run_vec(0);
        dbg_a1 = 4'd4;
        #1;
        chk("dbg_w4_after_sw", dbg_d1, 32'h8765_4321);
        for (int i = 1; i <= 20; i++) run_vec(i);

        // Error vectors must have left memory untouched.
        dbg_a1 = 4'd0; #1; chk("dbg_w0", dbg_d1, 32'h0BAD_F00D);
        dbg_a1 = 4'd1; #1; chk("dbg_w1", dbg_d1, 32'h0000_0000);
        dbg_a1 = 4'd2; #1; chk("dbg_w2", dbg_d1, 32'h1122_5544);
        dbg_a1 = 4'd4; #1; chk("dbg_w4", dbg_d1, 32'hAB65_4321);

        for (int i = 21; i < vt.size(); i++) run_vec(i);
        dbg_a1 = 4'd1; #1; chk("dbg_w1_half", dbg_d1, 32'hBEEF_0000);

        // READ_LAT=4: a store, then back-to-back loads with valid held high.
        xact(4, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0001, rd, er, lat, pulse_ok);
        chk("l4_sw_lat", lat, 4);
        chk("l4_sw_err", {31'b0, er}, 32'd0);
        $display("l4 sw addr=0x20 -> err=%0d lat=%0d", er, lat);

        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
        v4 = 1'b1;
        for (int n = 0; n < 15; n++) begin
            rdy_seen[n] = ready4;
            rv_seen[n]  = rv4;
            if (rv4) begin
                chk($sformatf("b2b_rdata_n%0d", n), rd4, 32'h0000_0001);
                $display("b2b response at cycle %0d rdata=0x%08h", n, rd4);
            end
            if (n == 14) v4 = 1'b0;
            @(negedge clk);
        end
        // Acceptances at cycles 0,5,10; responses 4 cycles later.
        chk("b2b_ready_pattern", {17'b0, rdy_seen}, 32'b000010000100001);
        chk("b2b_rv_pattern", {17'b0, rv_seen}, 32'b100001000010000);

        // Reset while a load sits in WAIT: the response must be dropped.
        req_addr = 32'h20; v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        chk("wait_ready_low", {31'b0, ready4}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_ready_low", {31'b0, ready4}, 32'd0);
        chk("rstwait_rv", {31'b0, rv4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwait_ready_after", {31'b0, ready4}, 32'd1);
        chk("rstwait_rdata", rd4, 32'd0);
        chk("rstwait_err", {31'b0, er4}, 32'd0);
        any_rv = 1'b0;
        for (int n = 0; n < 6; n++) begin
            any_rv = any_rv | rv4;
            @(negedge clk);
        end
        chk("rstwait_no_resp", {31'b0, any_rv}, 32'd0);
        $display("reset during WAIT: ready=%0d rdata=0x%08h dropped_resp_seen=%0d", ready4, rd4, any_rv);
        dbg_a4 = 4'd8;
        #1;
        chk("rstwait_dbg_w8", dbg_d4, 32'h0000_0001);
        xact(4, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, pulse_ok);
        chk("l4_lw_after_rst", rd, 32'h0000_0001);
        chk("l4_lw_lat", lat, 4);
        chk("l4_lw_pulse", {31'b0, pulse_ok}, 32'd1);
        $display("l4 lw addr=0x20 -> rdata=0x%08h err=%0d lat=%0d", rd, er, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
